spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
SPI master shift engine downstream of apb_register_top; consumes its tx_data/ctrl_*/start_op outputs and returns rx_data/busy.
- Runs one fixed-length full-duplex transfer per start_op pulse.
- Generates SCLK from the system clock, drives one-hot active-low slave selects and MOSI, samples MISO.
- Supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, four SCLK rates.

Parameters:
DATA_W, 32, bits per transfer (equals register width)
DIV_BASE, 2, SCLK half-period in clk cycles at ctrl_scks=0; half-period H = DIV_BASE << ctrl_scks

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tx_data  in  DATA_W  word to transmit
ctrl_cpol  in  1  SCLK idle level
ctrl_cpha  in  1  0: sample leading edge; 1: sample trailing edge
ctrl_order  in  1  1: MSB first; 0: LSB first
ctrl_slave_en  in  4  slave select, one-hot expected
ctrl_rd  in  1  1: update rx_data at end of transfer
ctrl_scks  in  2  SCLK rate select
start_op  in  1  single-cycle start request
rx_data  out  DATA_W  last received word
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in
ss_n  out  4  active-low slave selects

Behaviour:
- Reset (async, rst=1): rx_data=0, busy=0, done=0, sclk=0, mosi=0, ss_n=4'hF, state IDLE, all counters 0.
- IDLE: sclk tracks ctrl_cpol (registered, 1-cycle delay); ss_n=F.
- Start acceptance:
  - start_op=1 with ctrl_slave_en!=0 is accepted on that clk edge.
  - On acceptance, latch tx_data, cpol, cpha, order, slave_en, rd, scks.
  - start_op with slave_en==0 is ignored (busy stays 0).
  - start_op while busy is ignored.
- State sequence after acceptance (busy=1 from the next cycle):
  - SETUP (H cycles): ss_n=~slave_en_latched. For CPHA=0, mosi = first bit from the first SETUP cycle.
  - XFER (2*DATA_W*H cycles): sclk toggles every H cycles, giving 2*DATA_W edges.
    - CPHA=0: sample miso on leading edges; shift mosi on trailing edges, except the last.
    - CPHA=1: shift mosi on leading edges, sample miso on trailing edges.
  - HOLD (H cycles): sclk at cpol, ss_n still asserted.
  - DONE (1 cycle): ss_n=F, done=1, busy=1. rx_data was written on the HOLD->DONE edge, only if rd latched=1; otherwise unchanged.
  - Return to IDLE: busy=0.
- Total busy cycles = (2*DATA_W+2)*H + 1, e.g. 133 at scks=0.
- Bit order:
  - order=1: mosi takes tx[DATA_W-1] first; received bits shift in at the LSB.
  - order=0: mosi takes tx[0] first; received bits shift in at the MSB.
  - Either way, loopback returns tx_data unchanged.
- Input changes during busy have no effect (latched copies are used).
- Reset mid-transfer aborts immediately to reset values; rx_data returns to 0.
- Non-one-hot slave_en: all selected lines assert (no error).

Decomposition:
- spi_pkg: state enum (IDLE, SETUP, XFER, HOLD, DONE), DATA_W default, and a function computing H from scks.
- Sub-module spi_clk_gen: half-period counter producing a tick every H cycles and a leading/trailing edge flag. It is enabled only in SETUP/XFER/HOLD and its counter is cleared on start.

Test Plan:
1. Mode 0, order=1, scks=0, slave_en=0001, rd=1, tx=A5A5_0F0F, miso looped to mosi -> ss_n=1110 during transfer; rx_data=A5A5_0F0F; done pulses once; busy high for 133 cycles.
2. Mode 3 (cpol=1, cpha=1), order=0, scks=2 (H=8), slave_en=0100, tx=0000_00A5, loopback -> sclk idles 1; first mosi bit = 1 (tx[0]); rx_data=0000_00A5; busy = 66*8+1 = 529 cycles.
3. rd=0, tx=1234_5678 after test 1 -> rx_data stays A5A5_0F0F; done still pulses.
4. start_op with slave_en=0000 -> busy stays 0, ss_n=F, sclk no toggles. Second start_op 10 cycles into an active transfer -> only one done pulse.
5. miso tied 1, order=1, rd=1, with tx_data/cpol changed mid-transfer -> rx_data=FFFF_FFFF; mosi still follows the originally latched word.
6. Assert rst at XFER cycle 40 -> same cycle: ss_n=F, busy=0, sclk=0, rx_data=0. A new start after reset completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master shift engine.
package spi_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int DIV_BASE_DEF = 2;
  localparam int HCNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

  // SCLK half-period in system clocks for a given rate select.
  function automatic logic [HCNT_W-1:0] half_period(input logic [HCNT_W-1:0] base,
                                                    input logic [1:0]        scks);
    return base << scks;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period down-counter: ticks every H enabled cycles and tracks whether the
// next SCLK edge is leading or trailing.
module spi_clk_gen
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              edge_en_i,
  input  logic [HCNT_W-1:0] half_i,
  output logic              tick_o,
  output logic              lead_o
);

  logic [HCNT_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = half_i - HCNT_W'(1);
      phase_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        cnt_d = half_i - HCNT_W'(1);
        if (edge_en_i) phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == '0);
  assign lead_o = ~phase_q;

endmodule

// File: rtl/spi_master_core.sv
// SPI master: one fixed-length full-duplex transfer per accepted start_op.
//   state | meaning
//   IDLE  | sclk follows ctrl_cpol, waiting for start_op
//   SETUP | slave selected, H cycles before first SCLK edge
//   XFER  | 2*DATA_W SCLK edges, shift/sample
//   HOLD  | H cycles, sclk back at cpol, slave still selected
//   DONE  | deselect, done pulse
module spi_master_core
  import spi_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DIV_BASE = DIV_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              ctrl_cpol,
  input  logic              ctrl_cpha,
  input  logic              ctrl_order,
  input  logic [3:0]        ctrl_slave_en,
  input  logic              ctrl_rd,
  input  logic [1:0]        ctrl_scks,
  input  logic              start_op,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [3:0]        ss_n
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [DATA_W-1:0] tx_rev, tx_ord, rx_in;
  logic              cpol_q, cpha_q, order_q, rd_q, sclk_q, mosi_q;
  logic [3:0]        sel_q;
  logic [1:0]        scks_q;
  logic [EW-1:0]     edge_q;
  logic [HCNT_W-1:0] half;
  logic              start_acc, tick, lead, active, last_edge, shift_edge, sample_edge;

  assign start_acc = (state_q == ST_IDLE) && start_op && (ctrl_slave_en != 4'h0);
  assign active    = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);
  // Reload value must come from the live input on the accepting edge.
  assign half      = half_period(HCNT_W'(DIV_BASE), start_acc ? ctrl_scks : scks_q);

  spi_clk_gen u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en_i      (active),
    .clr_i     (start_acc),
    .edge_en_i (state_q == ST_XFER),
    .half_i    (half),
    .tick_o    (tick),
    .lead_o    (lead)
  );

  // Internally always shift MSB-first; LSB-first words are bit-reversed on load.
  assign tx_rev      = {<<{tx_data}};
  assign tx_ord      = ctrl_order ? tx_data : tx_rev;
  assign rx_in       = order_q ? {rx_sh_q[DATA_W-2:0], miso} : {miso, rx_sh_q[DATA_W-1:1]};
  assign last_edge   = (edge_q == LAST_EDGE);
  assign shift_edge  = cpha_q ? lead : (!lead && !last_edge);
  assign sample_edge = cpha_q ? !lead : lead;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      order_q   <= 1'b0;
      rd_q      <= 1'b0;
      sel_q     <= 4'h0;
      scks_q    <= 2'b00;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        tx_sh_q <= ctrl_cpha ? tx_ord : (tx_ord << 1);
        if (!ctrl_cpha) mosi_q <= tx_ord[DATA_W-1];
        rx_sh_q <= '0;
        cpol_q  <= ctrl_cpol;
        cpha_q  <= ctrl_cpha;
        order_q <= ctrl_order;
        rd_q    <= ctrl_rd;
        sel_q   <= ctrl_slave_en;
        scks_q  <= ctrl_scks;
        edge_q  <= '0;
        sclk_q  <= ctrl_cpol;
      end else if (state_q == ST_IDLE) begin
        sclk_q <= ctrl_cpol;
      end else if ((state_q == ST_XFER) && tick) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + EW'(1);
        if (shift_edge) begin
          mosi_q  <= tx_sh_q[DATA_W-1];
          tx_sh_q <= tx_sh_q << 1;
        end
        if (sample_edge) rx_sh_q <= rx_in;
      end
      if ((state_q == ST_HOLD) && tick && rd_q) rx_data_q <= rx_sh_q;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = active ? ~sel_q : 4'hF;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: per-cycle waveform model plus directed cases.
module tb_spi_master_core;

  localparam int D = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [D-1:0]  tx_data;
  logic          ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd, start_op;
  logic [3:0]    ctrl_slave_en;
  logic [1:0]    ctrl_scks;
  logic [D-1:0]  rx_data;
  logic          busy, done, sclk, mosi, miso;
  logic [3:0]    ss_n;
  logic          miso_loop, miso_const;

  assign miso = miso_loop ? mosi : miso_const;

  spi_master_core #(.DATA_W(D), .DIV_BASE(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha),
    .ctrl_order(ctrl_order), .ctrl_slave_en(ctrl_slave_en), .ctrl_rd(ctrl_rd),
    .ctrl_scks(ctrl_scks), .start_op(start_op), .rx_data(rx_data), .busy(busy),
    .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one transfer described by its latched settings and the cycle index t
  // since acceptance (t=1 is the first busy cycle, t=N the done cycle).
  bit           m_act;
  int           m_t, m_n, m_h;
  logic [D-1:0] m_tx, m_rxw, m_rx;
  logic         m_cpol, m_cpha, m_order, m_rd, m_sclk_idle;
  logic [3:0]   m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_t = 0; m_rx = '0; m_sclk_idle = 1'b0;
    end else if (m_act) begin
      m_t++;
      if (m_t == m_n && m_rd) m_rx = m_rxw;
      if (m_t > m_n) begin m_act = 0; m_sclk_idle = m_cpol; end
    end else begin
      m_sclk_idle = ctrl_cpol;
      if (start_op && ctrl_slave_en != 4'h0) begin
        m_tx = tx_data; m_cpol = ctrl_cpol; m_cpha = ctrl_cpha; m_order = ctrl_order;
        m_rd = ctrl_rd; m_sel = ctrl_slave_en;
        m_h = 2 << ctrl_scks;
        m_n = (2 * D + 2) * m_h + 1;
        m_rxw = miso_loop ? tx_data : {D{miso_const}};
        m_t = 1; m_act = 1;
      end
    end
  end

  always @(negedge clk) begin
    int e, idx;
    logic [3:0] ss_exp;
    logic mosi_ok;
    if (!rst) begin
      if (m_act) begin
        // Number of SCLK edges already produced before this cycle.
        e = (m_t - 1) / m_h - 1;
        if (e < 0) e = 0;
        if (e > 2 * D) e = 2 * D;
        ss_exp = (m_t < m_n) ? ~m_sel : 4'hF;
        check("busy", busy, 1);
        check("done", done, m_t == m_n);
        check("ss_n", ss_n, ss_exp);
        check("sclk", sclk, m_cpol ^ e[0]);
        mosi_ok = 1'b1;
        if (!m_cpha) idx = (e / 2 > D - 1) ? D - 1 : e / 2;
        else if (e >= 1) idx = (e + 1) / 2 - 1;
        else mosi_ok = 1'b0;
        if (mosi_ok) check("mosi", mosi, m_order ? m_tx[D-1-idx] : m_tx[idx]);
      end else begin
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
        check("ss_n_idle", ss_n, 4'hF);
        check("sclk_idle", sclk, m_sclk_idle);
      end
      check("rx_data", rx_data, m_rx);
    end
  end

  task automatic run_xfer(input logic [31:0] tx, input logic cpol, input logic cpha,
                          input logic order, input logic [3:0] sel, input logic rd,
                          input logic [1:0] scks, output int busy_cyc, output int done_cnt);
    @(posedge clk); #1;
    tx_data = tx; ctrl_cpol = cpol; ctrl_cpha = cpha; ctrl_order = order;
    ctrl_slave_en = sel; ctrl_rd = rd; ctrl_scks = scks; start_op = 1'b1;
    @(posedge clk); #1;
    start_op = 1'b0;
    busy_cyc = 0; done_cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (!busy && busy_cyc > 0) break;
    end
  endtask

  int bc, dc, toggles;
  bit got;
  logic prev_sclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; tx_data = '0; ctrl_cpol = 0; ctrl_cpha = 0; ctrl_order = 1;
    ctrl_slave_en = 4'h0; ctrl_rd = 0; ctrl_scks = 2'b00; start_op = 0;
    miso_loop = 1'b1; miso_const = 1'b0;
    #1;
    check("rst_rx", rx_data, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ss_n", ss_n, 4'hF);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: mode 0, MSB first, loopback
    fork
      run_xfer(32'hA5A5_0F0F, 0, 0, 1, 4'b0001, 1, 2'd0, bc, dc);
      begin
        repeat (20) @(negedge clk);
        check("t1_ss_n", ss_n, 4'b1110);
      end
    join
    check("t1_busy_cycles", bc, 133);
    check("t1_done_pulses", dc, 1);
    check("t1_rx", rx_data, 32'hA5A5_0F0F);

    // 2: mode 3, LSB first, H=8
    @(posedge clk); #1 ctrl_cpol = 1'b1;
    repeat (3) @(negedge clk);
    check("t2_sclk_idle", sclk, 1);
    got = 0;
    fork
      run_xfer(32'h0000_00A5, 1, 1, 0, 4'b0100, 1, 2'd2, bc, dc);
      begin
        for (int i = 0; i < 200 && !got; i++) begin
          @(negedge clk);
          if (busy && sclk == 1'b0) begin
            got = 1;
            check("t2_first_mosi", mosi, 1);
          end
        end
        if (!got) check("t2_first_edge_seen", 0, 1);
      end
    join
    check("t2_busy_cycles", bc, 529);
    check("t2_done_pulses", dc, 1);
    check("t2_rx", rx_data, 32'h0000_00A5);

    // 3: rd=0 keeps previous rx_data
    run_xfer(32'h1234_5678, 0, 0, 1, 4'b0001, 0, 2'd0, bc, dc);
    check("t3_done_pulses", dc, 1);
    check("t3_rx_kept", rx_data, 32'h0000_00A5);
    run_xfer(32'hA5A5_0F0F, 0, 0, 1, 4'b0001, 1, 2'd0, bc, dc);
    run_xfer(32'h1234_5678, 0, 0, 1, 4'b0010, 0, 2'd0, bc, dc);
    check("t3_rx_kept2", rx_data, 32'hA5A5_0F0F);

    // 4a: start with no slave selected is ignored
    @(posedge clk); #1 ctrl_slave_en = 4'h0; start_op = 1'b1;
    @(posedge clk); #1 start_op = 1'b0;
    bc = 0; toggles = 0; prev_sclk = sclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (sclk !== prev_sclk) toggles++;
      prev_sclk = sclk;
    end
    check("t4_no_busy", bc, 0);
    check("t4_no_toggle", toggles, 0);
    check("t4_ss_n", ss_n, 4'hF);

    // 4b: second start during a transfer is ignored
    fork
      run_xfer(32'hC3C3_3C3C, 0, 1, 1, 4'b1000, 1, 2'd0, bc, dc);
      begin
        repeat (11) @(posedge clk);
        #2 start_op = 1'b1;
        @(posedge clk); #2 start_op = 1'b0;
      end
    join
    check("t4_busy_cycles", bc, 133);
    check("t4_done_pulses", dc, 1);
    check("t4_rx", rx_data, 32'hC3C3_3C3C);

    // 5: miso tied high, inputs disturbed mid-transfer
    miso_loop = 1'b0; miso_const = 1'b1;
    fork
      run_xfer(32'h0F0F_1234, 0, 1, 1, 4'b0001, 1, 2'd1, bc, dc);
      begin
        repeat (50) @(posedge clk);
        #2 tx_data = 32'h0; ctrl_cpol = 1'b1; ctrl_order = 1'b0; ctrl_scks = 2'd3;
      end
    join
    check("t5_busy_cycles", bc, 265);
    check("t5_rx", rx_data, 32'hFFFF_FFFF);
    miso_loop = 1'b1;

    // 6: reset in XFER cycle 40 (H=2 -> busy cycle 42)
    @(posedge clk); #1;
    tx_data = 32'h5555_AAAA; ctrl_cpol = 0; ctrl_cpha = 0; ctrl_order = 1;
    ctrl_slave_en = 4'b0010; ctrl_rd = 1; ctrl_scks = 2'd0; start_op = 1'b1;
    @(posedge clk); #1 start_op = 1'b0;
    repeat (41) @(posedge clk);
    #2 check("t6_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_ss_n", ss_n, 4'hF);
    check("t6_busy", busy, 0);
    check("t6_sclk", sclk, 0);
    check("t6_rx", rx_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_xfer(32'h3C3C_5AA5, 0, 0, 1, 4'b0001, 1, 2'd0, bc, dc);
    check("t6_busy_cycles", bc, 133);
    check("t6_done_pulses", dc, 1);
    check("t6_rx", rx_data, 32'h3C3C_5AA5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
